ann_result_decoder: RTL and testbench

Output stage directly downstream of the three-layer ANN core. When the ANN signals completion, this block snapshots the final-layer node outputs and scans them one per cycle to find the winning class and the runner-up score. It then decides whether the win margin is sufficient and drives the classified digit (or an "uncertain" dash) onto the board's seven-segment display.

---
 rtl/ann_result_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_ann_result_decoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_result_decoder.sv
// ---------------------------------------------------------------------------
// ann_result_decoder
//
// Output stage behind the three-layer ANN core. When the ANN finishes
// (start pulse), the final-layer scores are snapshotted and scanned one per
// cycle to find the winning class and the runner-up score. The win margin
// (best - second) decides whether the result is confident; the winning
// digit, or a dash when uncertain, is driven onto the seven-segment display.
//
// Parameters:
//   NUM_CLASSES  number of final-layer scores (2..16)
//   MARGIN       minimum signed (best - second) for a confident result
//
// Ports:
//   clk           in   clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   start         in   one-cycle pulse from the ANN done_processing
//   scores        in   NUM_CLASSES x 16-bit two's complement scores,
//                      sampled only when a scan is launched
//   busy          out  high while a scan is in progress
//   result_valid  out  one-cycle pulse when a new result is registered
//   class_idx     out  index of the winning class
//   uncertain     out  high when the win margin is below MARGIN
//   seven_seg     out  {dp,g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module ann_result_decoder #(
   parameter int NUM_CLASSES = 10,
   parameter int MARGIN      = 64
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic                         start,
   input  logic [NUM_CLASSES-1:0][15:0] scores,
   output logic                         busy,
   output logic                         result_valid,
   output logic [3:0]                   class_idx,
   output logic                         uncertain,
   output logic [7:0]                   seven_seg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      DECIDE = 2'd2
   } state_t;

   localparam logic [3:0]  LAST_IDX   = 4'(NUM_CLASSES - 1);
   localparam logic [15:0] MOST_NEG   = 16'h8000;
   localparam logic [7:0]  SEG_DASH   = 8'h40;

   // Segment pattern for a hexadecimal digit.
   function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
      logic [7:0] pat;
      case (digit)
         4'd0:    pat = 8'h3F;
         4'd1:    pat = 8'h06;
         4'd2:    pat = 8'h5B;
         4'd3:    pat = 8'h4F;
         4'd4:    pat = 8'h66;
         4'd5:    pat = 8'h6D;
         4'd6:    pat = 8'h7D;
         4'd7:    pat = 8'h07;
         4'd8:    pat = 8'h7F;
         4'd9:    pat = 8'h6F;
         4'd10:   pat = 8'h77;
         4'd11:   pat = 8'h7C;
         4'd12:   pat = 8'h39;
         4'd13:   pat = 8'h5E;
         4'd14:   pat = 8'h79;
         4'd15:   pat = 8'h71;
         default: pat = SEG_DASH;
      endcase
      return pat;
   endfunction

   state_t                       state_q,        state_d;
   logic [NUM_CLASSES-1:0][15:0] snap_q,         snap_d;
   logic [15:0]                  best_q,         best_d;
   logic [15:0]                  second_q,       second_d;
   logic [3:0]                   best_idx_q,     best_idx_d;
   logic [3:0]                   cnt_q,          cnt_d;
   logic                         busy_q,         busy_d;
   logic                         result_valid_q, result_valid_d;
   logic [3:0]                   class_idx_q,    class_idx_d;
   logic                         uncertain_q,    uncertain_d;
   logic [7:0]                   seven_seg_q,    seven_seg_d;

   logic [15:0]                  cur_s;
   logic signed [16:0]           diff_s;
   logic signed [31:0]           diff_ext_s;
   logic                         margin_low_s;

   // Score under inspection and win-margin evaluation.
   always_comb begin
      cur_s = 16'h0000;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         cur_s = (cnt_q == 4'(i)) ? snap_q[i] : cur_s;
      end
      // Both operands sign-extended to 17 bits: the full 16-bit signed range
      // difference (7FFF - 8000 = FFFF) fits without overflow.
      diff_s       = {best_q[15], best_q} - {second_q[15], second_q};
      diff_ext_s   = {{15{diff_s[16]}}, diff_s};
      margin_low_s = (diff_ext_s < MARGIN);
   end

   // Next-state and datapath logic of the scan FSM.
   always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      best_d      = best_q;
      second_d    = second_q;
      best_idx_d  = best_idx_q;
      cnt_d       = cnt_q;
      class_idx_d = class_idx_q;
      uncertain_d = uncertain_q;
      seven_seg_d = seven_seg_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               snap_d     = scores;
               best_d     = scores[0];
               second_d   = MOST_NEG;
               best_idx_d = 4'd0;
               cnt_d      = 4'd1;
               state_d    = SCAN;
            end else begin
               state_d    = IDLE;
            end
         end
         SCAN: begin
            // Strict compares: on a tie the lower index keeps "best" and the
            // later equal score becomes "second".
            if ($signed(cur_s) > $signed(best_q)) begin
               second_d   = best_q;
               best_d     = cur_s;
               best_idx_d = cnt_q;
            end else if ($signed(cur_s) > $signed(second_q)) begin
               second_d   = cur_s;
            end else begin
               second_d   = second_q;
            end
            if (cnt_q == LAST_IDX) begin
               state_d = DECIDE;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end
         DECIDE: begin
            uncertain_d = margin_low_s;
            class_idx_d = best_idx_q;
            seven_seg_d = margin_low_s ? SEG_DASH : seg_pattern(best_idx_q);
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // busy mirrors the registered state; result_valid follows DECIDE.
      busy_d         = (state_d != IDLE);
      result_valid_d = (state_q == DECIDE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         snap_q         <= '0;
         best_q         <= 16'h0000;
         second_q       <= 16'h0000;
         best_idx_q     <= 4'd0;
         cnt_q          <= 4'd0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         class_idx_q    <= 4'd0;
         uncertain_q    <= 1'b0;
         seven_seg_q    <= 8'h00;
      end else begin
         state_q        <= state_d;
         snap_q         <= snap_d;
         best_q         <= best_d;
         second_q       <= second_d;
         best_idx_q     <= best_idx_d;
         cnt_q          <= cnt_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
         class_idx_q    <= class_idx_d;
         uncertain_q    <= uncertain_d;
         seven_seg_q    <= seven_seg_d;
      end
   end

   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign class_idx    = class_idx_q;
   assign uncertain    = uncertain_q;
   assign seven_seg    = seven_seg_q;

endmodule

// File: tb/tb_ann_result_decoder.sv
// ---------------------------------------------------------------------------
// tb_ann_result_decoder
//
// Self-checking bench for ann_result_decoder at default parameters
// (NUM_CLASSES=10, MARGIN=64). Directed scenarios carry hand-derived
// expected values; randomized scans are checked against a top-two model
// computed directly over the score array.
// ---------------------------------------------------------------------------
module tb_ann_result_decoder;

   localparam int NUM  = 10;
   localparam int MARG = 64;

   typedef logic [NUM-1:0][15:0] vec_t;

   logic        clk;
   logic        n_rst;
   logic        start;
   vec_t        scores;
   logic        busy;
   logic        result_valid;
   logic [3:0]  class_idx;
   logic        uncertain;
   logic [7:0]  seven_seg;

   int vectors;
   int miscompares;

   logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   ann_result_decoder #(.NUM_CLASSES(NUM), .MARGIN(MARG)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .scores       (scores),
      .busy         (busy),
      .result_valid (result_valid),
      .class_idx    (class_idx),
      .uncertain    (uncertain),
      .seven_seg    (seven_seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: winner = first index holding the maximum; runner-up = maximum
   // over every other index.
   function automatic void model(input vec_t v, output logic [3:0] idx,
                                 output logic unc, output logic [7:0] seg);
      int b, s, bi, val;
      b  = int'($signed(v[0]));
      bi = 0;
      for (int i = 1; i < NUM; i++) begin
         val = int'($signed(v[i]));
         if (val > b) begin
            b  = val;
            bi = i;
         end
      end
      s = -32768;
      for (int j = 0; j < NUM; j++) begin
         val = int'($signed(v[j]));
         if (j != bi && val > s) s = val;
      end
      idx = 4'(bi);
      unc = ((b - s) < MARG);
      seg = unc ? 8'h40 : seg_tab[bi];
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < NUM; i++) v[i] = 16'($urandom);
      return v;
   endfunction

   function automatic vec_t fill_vec(input logic [15:0] val);
      vec_t v;
      for (int i = 0; i < NUM; i++) v[i] = val;
      return v;
   endfunction

   task automatic kick(input vec_t v);
      @(negedge clk);
      start  = 1'b1;
      scores = v;
   endtask

   // Follows one scan from its start edge through result_valid. Expects start
   // to be asserted for the coming edge. Optionally fires an extra start in
   // mid-scan, or chains a new start onto the result_valid cycle.
   task automatic run_scan(input string name, input logic [3:0] e_idx,
                           input logic e_unc, input logic [7:0] e_seg,
                           input bit inject, input bit chain, input vec_t next_v);
      @(posedge clk);
      for (int j = 0; j <= NUM; j++) begin
         @(negedge clk);
         vectors++;
         if (busy !== (j < NUM)) begin
            miscompares++;
            $display("FAIL %s busy cycle %0d: got %b want %b", name, j, busy, (j < NUM));
         end
         vectors++;
         if (result_valid !== (j == NUM)) begin
            miscompares++;
            $display("FAIL %s result_valid cycle %0d: got %b want %b", name, j,
                     result_valid, (j == NUM));
         end
         if (j == 0) begin
            start  = 1'b0;
            scores = rand_vec();
         end
         if (inject && j == 3) begin
            start  = 1'b1;
            scores = rand_vec();
         end
         if (inject && j == 4) start = 1'b0;
         if (j == NUM) begin
            vectors++;
            if (class_idx !== e_idx) begin
               miscompares++;
               $display("FAIL %s class_idx: got %0d want %0d", name, class_idx, e_idx);
            end
            vectors++;
            if (uncertain !== e_unc) begin
               miscompares++;
               $display("FAIL %s uncertain: got %b want %b", name, uncertain, e_unc);
            end
            vectors++;
            if (seven_seg !== e_seg) begin
               miscompares++;
               $display("FAIL %s seven_seg: got %h want %h", name, seven_seg, e_seg);
            end
            if (chain) begin
               start  = 1'b1;
               scores = next_v;
            end
         end
      end
   endtask

   task automatic check_outputs(input string name, input logic e_busy, input logic e_rv,
                                input logic [3:0] e_idx, input logic e_unc,
                                input logic [7:0] e_seg);
      vectors++;
      if ({busy, result_valid, class_idx, uncertain, seven_seg} !==
          {e_busy, e_rv, e_idx, e_unc, e_seg}) begin
         miscompares++;
         $display("FAIL %s: got busy=%b rv=%b idx=%0d unc=%b seg=%h want busy=%b rv=%b idx=%0d unc=%b seg=%h",
                  name, busy, result_valid, class_idx, uncertain, seven_seg,
                  e_busy, e_rv, e_idx, e_unc, e_seg);
      end
   endtask

   task automatic test_power_on();
      n_rst  = 1'b0;
      start  = 1'b0;
      scores = '0;
      #2;
      check_outputs("power_on_reset", 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      check_outputs("after_release", 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
   endtask

   task automatic test_clear_winner();
      vec_t v;
      for (int i = 0; i < NUM; i++) v[i] = 16'(10 * i);
      kick(v);
      run_scan("clear_step10", 4'd9, 1'b1, 8'h40, 1'b0, 1'b0, v);
      for (int i = 0; i < NUM; i++) v[i] = 16'(100 * i);
      kick(v);
      run_scan("clear_step100", 4'd9, 1'b0, 8'h6F, 1'b0, 1'b0, v);
   endtask

   task automatic test_hold();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_outputs("hold", 1'b0, 1'b0, 4'd9, 1'b0, 8'h6F);
      end
   endtask

   task automatic test_reset();
      vec_t v;
      v = fill_vec(16'd0);
      v[2] = 16'd1000;
      kick(v);
      @(posedge clk);
      for (int j = 0; j < 4; j++) @(negedge clk);
      start = 1'b0;
      n_rst = 1'b0;
      #1;
      check_outputs("mid_scan_reset", 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      @(negedge clk);
      n_rst = 1'b1;
      for (int j = 0; j < NUM + 2; j++) begin
         @(negedge clk);
         check_outputs("no_result_after_reset", 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      end
      kick(v);
      run_scan("fresh_after_reset", 4'd2, 1'b0, 8'h5B, 1'b0, 1'b0, v);
   endtask

   task automatic test_negative();
      vec_t v;
      v = fill_vec(16'hFED4);
      v[0] = 16'hFFFB;
      kick(v);
      run_scan("negative_idx0", 4'd0, 1'b0, 8'h3F, 1'b0, 1'b0, v);
   endtask

   task automatic test_tie_margin();
      vec_t v;
      v = fill_vec(16'd0);
      v[3] = 16'd500;
      v[7] = 16'd500;
      kick(v);
      run_scan("tie", 4'd3, 1'b1, 8'h40, 1'b0, 1'b0, v);
      v[7] = 16'd440;
      kick(v);
      run_scan("margin60", 4'd3, 1'b1, 8'h40, 1'b0, 1'b0, v);
      v[7] = 16'd436;
      kick(v);
      run_scan("margin64", 4'd3, 1'b0, 8'h4F, 1'b0, 1'b0, v);
   endtask

   task automatic test_extremes();
      vec_t v;
      v = fill_vec(16'h8000);
      v[4] = 16'h7FFF;
      kick(v);
      run_scan("extremes", 4'd4, 1'b0, 8'h66, 1'b0, 1'b0, v);
   endtask

   task automatic test_ignored_start();
      vec_t v;
      for (int i = 0; i < NUM; i++) v[i] = 16'(100 * i);
      kick(v);
      run_scan("ignored_start", 4'd9, 1'b0, 8'h6F, 1'b1, 1'b0, v);
   endtask

   task automatic test_back_to_back();
      vec_t v1, v2;
      v1 = fill_vec(16'hFED4);
      v1[0] = 16'hFFFB;
      v2 = fill_vec(16'h8000);
      v2[4] = 16'h7FFF;
      kick(v1);
      run_scan("b2b_first", 4'd0, 1'b0, 8'h3F, 1'b0, 1'b1, v2);
      run_scan("b2b_second", 4'd4, 1'b0, 8'h66, 1'b0, 1'b0, v2);
   endtask

   task automatic test_random();
      vec_t v;
      logic [3:0] e_idx;
      logic e_unc;
      logic [7:0] e_seg;
      logic [15:0] base;
      for (int n = 0; n < 30; n++) begin
         if (n % 2 == 0) begin
            v = rand_vec();
         end else begin
            // Clustered scores make ties and near-threshold margins likely.
            base = 16'($urandom);
            for (int i = 0; i < NUM; i++) v[i] = base + 16'($urandom_range(0, 80));
            if (n % 3 == 0) v[$urandom_range(0, NUM - 1)] = base + 16'd200;
         end
         model(v, e_idx, e_unc, e_seg);
         kick(v);
         run_scan("random", e_idx, e_unc, e_seg, (n % 5 == 1), 1'b0, v);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_power_on();
      test_clear_winner();
      test_hold();
      test_reset();
      test_negative();
      test_tie_margin();
      test_extremes();
      test_ignored_start();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
